// File: rtl/mram_burst_ctrl_pkg.sv
// Shared types and constants for the serial-to-MRAM burst controller.
// No logic; FSM state encoding, select-bit positions and control idle level.
// No flow control.
package mram_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_SH,
        DATA_SH,
        SETUP,
        ACCESS,
        RECOVER,
        SHOUT,
        DONE
    } state_t;

    localparam int SEL_WR = 0;
    localparam int SEL_LO = 1;
    localparam int SEL_UP = 2;

    // MRAM strobes are active-low, so idle is a high level.
    localparam logic CTRL_INACTIVE = 1'b1;

endpackage

// File: rtl/mram_burst_ctrl_shift_reg.sv
// Shift register with parallel load: SIPO or PISO depending on use.
// Load or shift takes effect at the next clk edge; load wins over shift.
// No flow control; the owner sequences load/shift_en.
module mram_shift_reg #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_dat,
    input  logic             shift_en,
    input  logic             ser_in,
    output logic [WIDTH-1:0] par_out,
    output logic             ser_out
);

    logic [WIDTH-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = load_dat;
        end else if (shift_en) begin
            if (MSB_FIRST) begin
                sr_d = {sr_q[WIDTH-2:0], ser_in};
            end else begin
                sr_d = {ser_in, sr_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign par_out = sr_q;
    assign ser_out = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];

endmodule

// File: rtl/mram_burst_ctrl.sv
// Serial link to async MRAM burst controller: serial address in, 1..2^LEN_W words moved.
// Latency: 1+ADDR_W+(len+1)*(DATA_W+ACCESS_CYC+2) cycles from start to done.
// No backpressure: start is ignored while busy, serial bits are consumed on fixed cycles.
module mram_burst_ctrl
    import mram_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 16,
    parameter int LEN_W      = 4,
    parameter int ACCESS_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        read_write_sel,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic              addr_in,
    input  logic              data_in,
    output logic              ser_data_out,
    output logic              ser_valid,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
    input  logic [DATA_W-1:0] mram_dq_in,
    output logic              chip_en,
    output logic              write_en,
    output logic              out_en,
    output logic              lower_byte_en,
    output logic              upper_byte_en
);

    localparam int HALF  = DATA_W / 2;
    localparam int CNT_W = $clog2((ADDR_W > DATA_W ? ADDR_W : DATA_W) + 1);
    localparam int ACC_W = $clog2(ACCESS_CYC + 1);

    state_t             state_q, state_d;
    logic [2:0]         sel_q, sel_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   word_q, word_d;
    logic [CNT_W-1:0]   bit_q, bit_d;
    logic [ACC_W-1:0]   acc_q, acc_d;

    logic addr_shift, addr_load, data_shift, rd_load, rd_shift;
    logic more_words, rd_ser;
    logic [ADDR_W-1:0] addr_inc;
    logic [DATA_W-1:0] rd_word, rd_par_unused;
    logic addr_ser_unused, data_ser_unused;

    assign more_words = (word_q != len_q);
    assign addr_inc   = addr_out + ADDR_W'(1);
    // Disabled lanes are zeroed at capture so they shift out as 0.
    assign rd_word    = mram_dq_in & {{HALF{sel_q[SEL_UP]}}, {HALF{sel_q[SEL_LO]}}};

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        len_d      = len_q;
        word_d     = word_q;
        bit_d      = bit_q;
        acc_d      = acc_q;
        addr_shift = 1'b0;
        addr_load  = 1'b0;
        data_shift = 1'b0;
        rd_load    = 1'b0;
        rd_shift   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sel_d   = read_write_sel;
                    len_d   = burst_len;
                    word_d  = '0;
                    bit_d   = '0;
                    state_d = (read_write_sel[SEL_UP:SEL_LO] == 2'b00) ? DONE : ADDR_SH;
                end
            end
            ADDR_SH: begin
                addr_shift = 1'b1;
                if (bit_q == CNT_W'(ADDR_W - 1)) begin
                    bit_d   = '0;
                    state_d = sel_q[SEL_WR] ? DATA_SH : SETUP;
                end else begin
                    bit_d = bit_q + CNT_W'(1);
                end
            end
            DATA_SH: begin
                data_shift = 1'b1;
                if (bit_q == CNT_W'(DATA_W - 1)) begin
                    bit_d   = '0;
                    state_d = SETUP;
                end else begin
                    bit_d = bit_q + CNT_W'(1);
                end
            end
            SETUP: begin
                acc_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (acc_q == ACC_W'(ACCESS_CYC - 1)) begin
                    rd_load = ~sel_q[SEL_WR];
                    state_d = RECOVER;
                end else begin
                    acc_d = acc_q + ACC_W'(1);
                end
            end
            RECOVER: begin
                addr_load = more_words;
                if (!sel_q[SEL_WR]) begin
                    state_d = SHOUT;
                end else if (more_words) begin
                    word_d  = word_q + LEN_W'(1);
                    state_d = DATA_SH;
                end else begin
                    state_d = DONE;
                end
            end
            SHOUT: begin
                rd_shift = 1'b1;
                if (bit_q == CNT_W'(DATA_W - 1)) begin
                    bit_d = '0;
                    if (more_words) begin
                        word_d  = word_q + LEN_W'(1);
                        state_d = SETUP;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    bit_d = bit_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            len_q   <= '0;
            word_q  <= '0;
            bit_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            len_q   <= len_d;
            word_q  <= word_d;
            bit_q   <= bit_d;
            acc_q   <= acc_d;
        end
    end

    mram_shift_reg #(.WIDTH(ADDR_W), .MSB_FIRST(1'b0)) u_addr_sipo (
        .clk(clk), .rst(rst), .load(addr_load), .load_dat(addr_inc),
        .shift_en(addr_shift), .ser_in(addr_in),
        .par_out(addr_out), .ser_out(addr_ser_unused)
    );

    mram_shift_reg #(.WIDTH(DATA_W), .MSB_FIRST(1'b0)) u_wdata_sipo (
        .clk(clk), .rst(rst), .load(1'b0), .load_dat('0),
        .shift_en(data_shift), .ser_in(data_in),
        .par_out(data_out), .ser_out(data_ser_unused)
    );

    mram_shift_reg #(.WIDTH(DATA_W), .MSB_FIRST(1'b1)) u_rdata_piso (
        .clk(clk), .rst(rst), .load(rd_load), .load_dat(rd_word),
        .shift_en(rd_shift), .ser_in(1'b0),
        .par_out(rd_par_unused), .ser_out(rd_ser)
    );

    always_comb begin
        busy          = (state_q != IDLE) && (state_q != DONE);
        done          = (state_q == DONE);
        err           = done && (sel_q[SEL_UP:SEL_LO] == 2'b00);
        ser_valid     = (state_q == SHOUT);
        ser_data_out  = ser_valid & rd_ser;
        data_oe       = sel_q[SEL_WR] &&
                        ((state_q == SETUP) || (state_q == ACCESS) || (state_q == RECOVER));
        chip_en       = CTRL_INACTIVE;
        write_en      = CTRL_INACTIVE;
        out_en        = CTRL_INACTIVE;
        lower_byte_en = CTRL_INACTIVE;
        upper_byte_en = CTRL_INACTIVE;
        if (state_q == ACCESS) begin
            chip_en       = ~CTRL_INACTIVE;
            write_en      = sel_q[SEL_WR]  ? ~CTRL_INACTIVE : CTRL_INACTIVE;
            out_en        = sel_q[SEL_WR]  ? CTRL_INACTIVE  : ~CTRL_INACTIVE;
            lower_byte_en = sel_q[SEL_LO]  ? ~CTRL_INACTIVE : CTRL_INACTIVE;
            upper_byte_en = sel_q[SEL_UP]  ? ~CTRL_INACTIVE : CTRL_INACTIVE;
        end
    end

endmodule

// File: tb/tb_mram_burst_ctrl.sv
// Bench for mram_burst_ctrl: vector table of transactions, MRAM window and serial-read scoreboards.
module tb_mram_burst_ctrl;

    localparam int A  = 20;
    localparam int D  = 16;
    localparam int AC = 4;
    localparam int WORD_CYC = D + AC + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [2:0]    read_write_sel = 3'b000;
    logic [3:0]    burst_len = 4'd0;
    logic          addr_in = 1'b0;
    logic          data_in = 1'b0;
    logic          ser_data_out, ser_valid, busy, done, err, data_oe;
    logic [A-1:0]  addr_out;
    logic [D-1:0]  data_out;
    logic [D-1:0]  mram_dq_in;
    logic          chip_en, write_en, out_en, lower_byte_en, upper_byte_en;

    logic [D-1:0]  rd_base = 16'h0000;
    bit            abort_win = 1'b0;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    // Read data depends on the address so a wrong address shows up in the shifted word.
    assign mram_dq_in = out_en ? 16'h0000 : (rd_base ^ {12'h000, addr_out[3:0]});

    mram_burst_ctrl #(.ADDR_W(A), .DATA_W(D), .LEN_W(4), .ACCESS_CYC(AC)) dut (
        .clk(clk), .rst(rst), .start(start), .read_write_sel(read_write_sel),
        .burst_len(burst_len), .addr_in(addr_in), .data_in(data_in),
        .ser_data_out(ser_data_out), .ser_valid(ser_valid), .busy(busy),
        .done(done), .err(err), .addr_out(addr_out), .data_out(data_out),
        .data_oe(data_oe), .mram_dq_in(mram_dq_in), .chip_en(chip_en),
        .write_en(write_en), .out_en(out_en), .lower_byte_en(lower_byte_en),
        .upper_byte_en(upper_byte_en)
    );

    typedef struct {
        logic [2:0]  sel;
        logic [3:0]  len;
        logic [19:0] addr;
        logic [15:0] wbase;
        logic [15:0] rbase;
        int          exp_cyc;
        logic        exp_err;
        int          restart_at;
    } vec_t;

    typedef struct {
        logic        wr;
        logic [19:0] addr;
        logic [15:0] data;
        logic [3:0]  ctrl;   // {write_en, out_en, upper_byte_en, lower_byte_en}
    } win_t;

    vec_t        vecs[7];
    win_t        exp_win[$];
    logic [15:0] exp_rd[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // MRAM window monitor: one expected entry per chip_en low pulse.
    int   low_cnt = 0;
    bit   in_win = 1'b0;
    bit   stable = 1'b1;
    win_t cap;
    win_t e;
    always @(negedge clk) begin
        if (!chip_en) begin
            if (!in_win) begin
                in_win   = 1'b1;
                low_cnt  = 0;
                stable   = 1'b1;
                cap.wr   = !write_en;
                cap.addr = addr_out;
                cap.data = data_out;
                cap.ctrl = {write_en, out_en, upper_byte_en, lower_byte_en};
            end
            low_cnt++;
            if (addr_out !== cap.addr || data_out !== cap.data ||
                {write_en, out_en, upper_byte_en, lower_byte_en} !== cap.ctrl ||
                (cap.wr && !data_oe))
                stable = 1'b0;
        end else if (in_win) begin
            in_win = 1'b0;
            if (abort_win) begin
                abort_win = 1'b0;
            end else if (exp_win.size() == 0) begin
                chk("win_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_win.pop_front();
                chk("win_addr", 32'(cap.addr), 32'(e.addr));
                chk("win_len", low_cnt, AC);
                chk("win_ctrl", 32'(cap.ctrl), 32'(e.ctrl));
                chk("win_stable", 32'(stable), 32'd1);
                if (e.wr) chk("win_wdata", 32'(cap.data), 32'(e.data));
            end
        end
    end

    // Serial read monitor: MSB-first words.
    int          rbits = 0;
    logic [15:0] racc = 16'h0;
    always @(negedge clk) begin
        if (rst) begin
            rbits = 0;
        end else if (ser_valid) begin
            racc = {racc[14:0], ser_data_out};
            rbits++;
            if (rbits == D) begin
                rbits = 0;
                if (exp_rd.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
                else chk("rd_word", 32'(racc), 32'(exp_rd.pop_front()));
            end
        end
    end

    task automatic run_txn(input vec_t v);
        win_t        w;
        logic [15:0] wd;
        int          cyc_seen = -1;
        int          rel, k, j;
        bit          viol = 1'b0;
        bit          busy_bad = 1'b0;
        logic        err_at_done = 1'b0;
        for (int n = 0; n <= int'(v.len); n++) begin
            w.wr   = v.sel[0];
            w.addr = 20'(v.addr + 20'(n));
            w.data = v.wbase + 16'(n);
            w.ctrl = {~v.sel[0], v.sel[0], ~v.sel[2], ~v.sel[1]};
            if (v.sel[2:1] != 2'b00) begin
                exp_win.push_back(w);
                if (!v.sel[0])
                    exp_rd.push_back((v.rbase ^ {12'h000, w.addr[3:0]}) &
                                     {{8{v.sel[2]}}, {8{v.sel[1]}}});
            end
        end
        rd_base = v.rbase;
        @(negedge clk);
        start = 1'b1;
        read_write_sel = v.sel;
        burst_len = v.len;
        for (int cyc = 1; cyc <= v.exp_cyc + 20 && cyc_seen < 0; cyc++) begin
            @(negedge clk);
            start = (cyc == v.restart_at);
            if (start) begin
                read_write_sel = 3'b001;
                burst_len = 4'd7;
            end
            if (cyc <= A) addr_in = v.addr[cyc-1];
            rel = cyc - A - 1;
            if (v.sel[0] && rel >= 0) begin
                k = rel / WORD_CYC;
                j = rel % WORD_CYC;
                if (j < D && k <= int'(v.len)) begin
                    wd = v.wbase + 16'(k);
                    data_in = wd[j];
                end
            end
            if (busy !== (cyc < v.exp_cyc)) busy_bad = 1'b1;
            if ((!write_en && !out_en) || (!write_en && !v.sel[0]) || (!out_en && v.sel[0]) ||
                (!upper_byte_en && !v.sel[2]) || (!lower_byte_en && !v.sel[1]) ||
                (!chip_en && v.sel[2:1] == 2'b00) || (data_oe && !v.sel[0]))
                viol = 1'b1;
            if (done === 1'b1) begin
                cyc_seen = cyc;
                err_at_done = err;
            end
        end
        start = 1'b0;
        chk("done_cyc", cyc_seen, v.exp_cyc);
        chk("err", 32'(err_at_done), 32'(v.exp_err));
        chk("busy", 32'(busy_bad), 32'd0);
        chk("ctrl_rule", 32'(viol), 32'd0);
    endtask

    initial begin
        //        sel     len  addr       wbase     rbase     cyc  err  restart
        vecs[0] = '{3'b111, 4'd0, 20'h00000, 16'h5555, 16'h0000, 43, 1'b0, 0};
        vecs[1] = '{3'b011, 4'd2, 20'hFFFFE, 16'h00A7, 16'h0000, 87, 1'b0, 0};
        vecs[2] = '{3'b110, 4'd0, 20'h00001, 16'h0000, 16'hA5C2, 43, 1'b0, 0};
        vecs[3] = '{3'b100, 4'd1, 20'h00010, 16'h0000, 16'hA5C3, 65, 1'b0, 0};
        vecs[4] = '{3'b001, 4'd3, 20'h12345, 16'h0000, 16'h0000,  1, 1'b1, 0};
        vecs[5] = '{3'b101, 4'd1, 20'h7FFFF, 16'h1234, 16'h0000, 65, 1'b0, 30};
        vecs[6] = '{3'b010, 4'd2, 20'hFFFFF, 16'h0000, 16'h3C96, 87, 1'b0, 0};

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done_err", 32'({done, err, ser_valid, ser_data_out, data_oe}), 32'd0);
        chk("rst_addr", 32'(addr_out), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_ctrl", 32'({chip_en, write_en, out_en, lower_byte_en, upper_byte_en}), 32'h1F);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_txn(vecs[i]);

        // Reset in the middle of a write access window.
        @(negedge clk);
        start = 1'b1;
        read_write_sel = 3'b111;
        burst_len = 4'd0;
        for (int cyc = 1; cyc <= 39; cyc++) begin
            logic [19:0] ra;
            logic [15:0] rd;
            ra = 20'h12345;
            rd = 16'hBEEF;
            @(negedge clk);
            start = 1'b0;
            if (cyc <= A) addr_in = ra[cyc-1];
            else if (cyc <= A + D) data_in = rd[cyc-A-1];
            if (cyc == 39) begin
                chk("pre_rst_ce", 32'(chip_en), 32'd0);
                abort_win = 1'b1;
                rst = 1'b1;
            end
        end
        @(negedge clk);
        chk("mid_rst_ctrl", 32'({chip_en, write_en, out_en, lower_byte_en, upper_byte_en}), 32'h1F);
        chk("mid_rst_busy_oe", 32'({busy, data_oe, done}), 32'd0);
        rst = 1'b0;

        for (int i = 5; i < 7; i++) run_txn(vecs[i]);
        run_txn(vecs[2]);

        repeat (5) @(negedge clk);
        chk("win_q_empty", exp_win.size(), 0);
        chk("rd_q_empty", exp_rd.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
